unified_mem_arbiter: RTL
========================

Name: unified_mem_arbiter

Overview:
- Shares a single memory bus between instruction fetch (IF stage) and data access (MEM stage) of the 5-stage pipeline.
- One outstanding transaction at a time. MEM has fixed priority, bounded by a starvation limit for IF.
- Generates per-stage stall signals that drive the pipeline-register enables, and runs a per-transaction response watchdog.

Parameters:
- XLEN, 32, address/data width.
- STARVE_LIMIT, 4, consecutive data grants allowed while IF is waiting before IF is forced to win.
- TIMEOUT, 64, cycles in a wait state without a response before the transaction is aborted.

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- if_req  in  1  IF wants an instruction word
- if_addr  in  XLEN  fetch address
- if_rdata  out  XLEN  instruction data, valid when if_done
- if_done  out  1  fetch complete this cycle
- if_stall  out  1  if_req && !if_done
- dmem_cmd  in  2  BUS_NONE/BUS_LOAD/BUS_STORE from MEM stage
- dmem_addr  in  XLEN  data address
- dmem_wdata  in  XLEN  store data
- dmem_rdata  out  XLEN  load data, valid when dmem_done
- dmem_done  out  1  data access complete this cycle
- mem_stall  out  1  (dmem_cmd!=BUS_NONE) && !dmem_done
- mem_cmd  out  2  command to memory
- mem_addr  out  XLEN  address to memory
- mem_wdata  out  XLEN  write data to memory
- mem_resp_valid  in  1  memory response/ack for the outstanding command (loads and stores)
- mem_rdata  in  XLEN  memory read data
- bus_err  out  1  sticky; set on watchdog timeout

Behaviour:
- FSM states: IDLE, WAIT_D, WAIT_I. Reset state is IDLE.
- Reset values: starve_cnt=0, wd_cnt=0, bus_err=0.
- While rst is high: mem_cmd=BUS_NONE, if_done=0, dmem_done=0; mem_addr and mem_wdata are 0.
- IDLE grant rule, evaluated in order:
  - Data grant when dmem_cmd!=BUS_NONE and (starve_cnt<STARVE_LIMIT or !if_req).
  - Otherwise IF grant when if_req.
  - Otherwise no grant.
- Issue cycle: mem_cmd/mem_addr/mem_wdata are driven combinationally from the granted requester in the IDLE cycle.
  - IF issues BUS_LOAD with if_addr and mem_wdata=0.
  - Next state is WAIT_D or WAIT_I.
- No grant: mem_cmd=BUS_NONE; mem_addr and mem_wdata hold 0.
- WAIT_x: mem_cmd=BUS_NONE.
  - On mem_resp_valid: x_done=1 combinationally, x_rdata=mem_rdata passthrough, next state IDLE.
  - Minimum transaction is 2 cycles (issue, then response). Back-to-back issue is possible on the cycle after done.
- Done outputs and the read-data passthrough are never asserted outside the matching WAIT state.
- Non-selected rdata output is driven 0.
- mem_resp_valid in IDLE is ignored silently (covers a late response after reset or abort).
- Starvation counter:
  - On a data grant while if_req=1: starve_cnt increments, saturating at STARVE_LIMIT.
  - On an IF grant: starve_cnt clears.
  - On a data grant while if_req=0: starve_cnt clears.
  - Width is clog2(STARVE_LIMIT+1).
- Watchdog:
  - wd_cnt clears on entering a WAIT state and increments each WAIT cycle without a response.
  - When wd_cnt==TIMEOUT-1 with no response: bus_err<=1 (sticky until rst), next state IDLE, no done pulse.
  - The still-held request is re-arbitrated and reissued.
- Requests must be held stable until done. A request that drops mid-WAIT does not cancel the transaction; the response is consumed and done still pulses.
- Stalls: if_stall and mem_stall are purely combinational from request and done.
- Pipeline use: IF/ID is enabled by !if_stall && !mem_stall; ID/EX and EX/MEM are enabled by !mem_stall.

Decomposition:
- Shared package sys_defs holds BUS_NONE/BUS_LOAD/BUS_STORE encodings and the arbiter state enum arb_state_t {IDLE, WAIT_D, WAIT_I}.
- One natural sub-module, arb_watchdog: counter plus timeout pulse, parameterised by TIMEOUT.
- Grant logic and the starvation counter stay in the top module.

Test Plan:
- Reset with no requests: mem_cmd=BUS_NONE, all done=0, bus_err=0. Then if_req=1 at addr 0x100 with response after 1 cycle: BUS_LOAD 0x100 issued cycle 0, if_done with if_rdata=mem_rdata in cycle 1, if_stall=1 only in cycle 0.
- Simultaneous if_req and dmem_cmd=BUS_STORE at 0x2000, wdata 0xDEADBEEF: store issued first with mem_wdata=0xDEADBEEF; IF issued in the IDLE cycle after dmem_done; if_stall high throughout.
- Continuous data requests with if_req held and STARVE_LIMIT=4: exactly 4 data grants, then 1 IF grant, then starve_cnt=0 and data resumes.
- Memory silent for 64 cycles in WAIT_D: bus_err=1 on cycle 64, no dmem_done, and the load is reissued on the next IDLE cycle.
- rst asserted mid-WAIT_I, then a late mem_resp_valid after reset: state IDLE, no if_done, bus_err=0.
- Response delayed 5 cycles for a load of 0x1234: mem_stall=1 for 5 cycles, dmem_done and dmem_rdata=0x1234 in cycle 5 only.

Source files
------------

// File: rtl/sys_defs.sv
// -----------------------------------------------------------------------------
// sys_defs
// Shared definitions for the pipeline memory subsystem.
//   - Bus command encodings used on the MEM-stage request port and memory port.
//   - Arbiter FSM state type shared by the arbiter and any checker modules.
// -----------------------------------------------------------------------------
package sys_defs;

    localparam logic [1:0] BUS_NONE  = 2'b00;
    localparam logic [1:0] BUS_LOAD  = 2'b01;
    localparam logic [1:0] BUS_STORE = 2'b10;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        WAIT_D = 2'b01,
        WAIT_I = 2'b10
    } arb_state_t;

endpackage

// File: rtl/arb_watchdog.sv
// -----------------------------------------------------------------------------
// arb_watchdog
// Response watchdog for a single outstanding memory transaction.
//   clk, rst : clock and asynchronous active-high reset
//   start    : a transaction is issued this cycle (counter restarts)
//   active   : arbiter is waiting for a response this cycle
//   resp     : memory response seen this cycle
//   timeout  : pulses in the last allowed waiting cycle with no response
// The counter holds the number of completed waiting cycles, so timeout
// fires in waiting cycle number TIMEOUT (counting from 1).
// -----------------------------------------------------------------------------
module arb_watchdog #(
    parameter int TIMEOUT = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic active,
    input  logic resp,
    output logic timeout
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] wd_cnt_r;

    // Waiting-cycle counter: restarts on issue, advances on each silent wait cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wd_cnt_r <= '0;
        end else if (start) begin
            wd_cnt_r <= '0;
        end else if (active && !resp) begin
            wd_cnt_r <= wd_cnt_r + CW'(1);
        end else begin
            wd_cnt_r <= wd_cnt_r;
        end
    end

    // Timeout only in a silent wait cycle; a response in the same cycle wins.
    always_comb begin
        timeout = 1'b0;
        if (active && !resp && (wd_cnt_r == LAST)) begin
            timeout = 1'b1;
        end else begin
            timeout = 1'b0;
        end
    end

endmodule

// File: rtl/unified_mem_arbiter.sv
// -----------------------------------------------------------------------------
// unified_mem_arbiter
// Shares one memory bus between instruction fetch and data access, with one
// transaction outstanding at a time. Data wins by default; after STARVE_LIMIT
// consecutive data grants while IF waits, IF is forced through.
//   IF port   : if_req, if_addr -> if_rdata, if_done, if_stall
//   MEM port  : dmem_cmd, dmem_addr, dmem_wdata -> dmem_rdata, dmem_done, mem_stall
//   Memory    : mem_cmd, mem_addr, mem_wdata -> mem_resp_valid, mem_rdata
//   Status    : bus_err (sticky watchdog timeout flag)
// Commands are issued combinationally in the IDLE cycle; the response is
// passed straight through to the owner in the following WAIT cycle(s).
// -----------------------------------------------------------------------------
module unified_mem_arbiter
    import sys_defs::*;
#(
    parameter int XLEN         = 32,
    parameter int STARVE_LIMIT = 4,
    parameter int TIMEOUT      = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            if_req,
    input  logic [XLEN-1:0] if_addr,
    output logic [XLEN-1:0] if_rdata,
    output logic            if_done,
    output logic            if_stall,
    input  logic [1:0]      dmem_cmd,
    input  logic [XLEN-1:0] dmem_addr,
    input  logic [XLEN-1:0] dmem_wdata,
    output logic [XLEN-1:0] dmem_rdata,
    output logic            dmem_done,
    output logic            mem_stall,
    output logic [1:0]      mem_cmd,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    input  logic            mem_resp_valid,
    input  logic [XLEN-1:0] mem_rdata,
    output logic            bus_err
);

    localparam int SW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

    arb_state_t    state_r;
    arb_state_t    state_nxt_s;
    logic [SW-1:0] starve_r;
    logic          grant_d_s;
    logic          grant_i_s;
    logic          resp_s;
    logic          waiting_s;
    logic          timeout_s;

    assign waiting_s = (state_r != IDLE);
    // A response while in reset can never complete a transaction.
    assign resp_s    = mem_resp_valid && !rst;

    // Grant decision in IDLE: data first unless IF has been starved long enough.
    always_comb begin
        grant_d_s = 1'b0;
        grant_i_s = 1'b0;
        if ((state_r == IDLE) && !rst) begin
            if ((dmem_cmd != BUS_NONE) && ((starve_r < STARVE_MAX) || !if_req)) begin
                grant_d_s = 1'b1;
            end else if (if_req) begin
                grant_i_s = 1'b1;
            end else begin
                grant_i_s = 1'b0;
            end
        end else begin
            grant_d_s = 1'b0;
        end
    end

    // Memory command port: driven only in the issue cycle, zero otherwise.
    always_comb begin
        mem_cmd   = BUS_NONE;
        mem_addr  = '0;
        mem_wdata = '0;
        if (grant_d_s) begin
            mem_cmd   = dmem_cmd;
            mem_addr  = dmem_addr;
            mem_wdata = dmem_wdata;
        end else if (grant_i_s) begin
            mem_cmd   = BUS_LOAD;
            mem_addr  = if_addr;
            mem_wdata = '0;
        end else begin
            mem_cmd   = BUS_NONE;
        end
    end

    // Completion, read-data passthrough and stalls for both requesters.
    always_comb begin
        if_done    = (state_r == WAIT_I) && resp_s;
        dmem_done  = (state_r == WAIT_D) && resp_s;
        if_rdata   = '0;
        dmem_rdata = '0;
        if (if_done) begin
            if_rdata = mem_rdata;
        end else if (dmem_done) begin
            dmem_rdata = mem_rdata;
        end else begin
            if_rdata = '0;
        end
        if_stall  = if_req && !if_done;
        mem_stall = (dmem_cmd != BUS_NONE) && !dmem_done;
    end

    // Next-state: issue moves to a wait state; response or timeout returns to IDLE.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (grant_d_s) begin
                    state_nxt_s = WAIT_D;
                end else if (grant_i_s) begin
                    state_nxt_s = WAIT_I;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            WAIT_D, WAIT_I: begin
                if (resp_s || timeout_s) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = state_r;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // Arbiter state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Starvation counter: counts data grants that bypass a waiting IF request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_r <= '0;
        end else if (grant_d_s && if_req) begin
            starve_r <= (starve_r < STARVE_MAX) ? (starve_r + SW'(1)) : STARVE_MAX;
        end else if (grant_d_s || grant_i_s) begin
            starve_r <= '0;
        end else begin
            starve_r <= starve_r;
        end
    end

    // Sticky bus error flag, cleared only by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus_err <= 1'b0;
        end else if (timeout_s) begin
            bus_err <= 1'b1;
        end else begin
            bus_err <= bus_err;
        end
    end

    arb_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk     (clk),
        .rst     (rst),
        .start   (grant_d_s || grant_i_s),
        .active  (waiting_s),
        .resp    (resp_s),
        .timeout (timeout_s)
    );

endmodule
